// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side controller for an asynchronous (dual-clock) FIFO.
//
// This block owns the binary/Gray write pointer and drives the write port of an
// external dual-port memory. It brings the read pointer into clk_wr through a
// two-flop synchronizer, and it uses that copy to produce a registered full
// flag and a registered occupancy count.
//
// Optional feature:
//   FIFO_ALMOST_FULL_EN - when this is defined, the almost_full port and its
//                         threshold compare exist. When it is undefined, both
//                         are absent.
//
// Ports:
//   clk_wr       in   write-domain clock (the only clock of this block)
//   rst_wr       in   synchronous, active-high reset
//   in_valid     in   upstream word valid
//   in_data      in   upstream word [WIDTH]
//   in_ready     out  block can accept a word
//   rd_ptr_gray  in   Gray read pointer from the read domain [LSIZE+1], async
//   wr_ptr_gray  out  registered Gray write pointer for the read domain [LSIZE+1]
//   mem_wr_en    out  memory write enable (accepted write this cycle)
//   mem_wr_addr  out  memory write address [LSIZE]
//   mem_data     out  memory write data [WIDTH]
//   full         out  FIFO full, registered
//   wr_count     out  occupancy as seen in the write domain, registered [LSIZE+1]
//   almost_full  out  occupancy >= AF_THRESH, registered (FIFO_ALMOST_FULL_EN only)

module fifo_wr_ctrl #(
  parameter int WIDTH     = 16,
  parameter int SIZE      = 64,
  parameter int LSIZE     = $clog2(SIZE),
  parameter int AF_THRESH = SIZE - 4
) (
  input  logic             clk_wr,
  input  logic             rst_wr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic [LSIZE:0]   rd_ptr_gray,
  output logic [LSIZE:0]   wr_ptr_gray,
  output logic             mem_wr_en,
  output logic [LSIZE-1:0] mem_wr_addr,
  output logic [WIDTH-1:0] mem_data,
  output logic             full,
  output logic [LSIZE:0]   wr_count
`ifdef FIFO_ALMOST_FULL_EN
  ,
  output logic             almost_full
`endif
);

  if (SIZE < 4 || (SIZE & (SIZE - 1)) != 0 || AF_THRESH > SIZE || AF_THRESH < 0)
  begin : g_bad_param
    $error("fifo_wr_ctrl: SIZE must be a power of two >= 4 and 0 <= AF_THRESH <= SIZE");
  end

  function automatic logic [LSIZE:0] bin2gray(input logic [LSIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [LSIZE:0] gray2bin(input logic [LSIZE:0] g);
    logic [LSIZE:0] b;
    b[LSIZE] = g[LSIZE];
    for (int i = LSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [LSIZE:0] wr_bin;
  logic [LSIZE:0] wr_bin_next;
  logic [LSIZE:0] wr_gray_next;
  logic [LSIZE:0] rd_sync1;
  logic [LSIZE:0] rd_sync2;
  logic [LSIZE:0] rd_bin_sync;
  logic [LSIZE:0] wr_count_next;
  logic [LSIZE:0] rd_gray_full;
  logic           full_next;
  // This flag is set by reset and stays set until the first clk_wr edge that
  // sees rst_wr low. Until then in_ready is held low.
  logic           rst_hold;

  // in_ready is built only from registered state and rst_wr. in_valid does not
  // feed it, so there is no combinational path from valid to ready.
  assign in_ready    = !full && !rst_hold && !rst_wr;
  assign mem_wr_en   = in_valid && in_ready;
  assign mem_wr_addr = wr_bin[LSIZE-1:0];
  assign mem_data    = in_data;

  assign wr_bin_next  = wr_bin + {{LSIZE{1'b0}}, mem_wr_en};
  assign wr_gray_next = bin2gray(wr_bin_next);
  assign rd_bin_sync  = gray2bin(rd_sync2);

  // The FIFO is full when the write pointer is exactly SIZE ahead of the read
  // pointer. In Gray code that means the top two bits are inverted and the
  // remaining bits are equal.
  assign rd_gray_full  = {~rd_sync2[LSIZE:LSIZE-1], rd_sync2[LSIZE-2:0]};
  assign full_next     = (wr_gray_next == rd_gray_full);
  assign wr_count_next = wr_bin_next - rd_bin_sync;

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      wr_bin      <= '0;
      wr_ptr_gray <= '0;
      rd_sync1    <= '0;
      rd_sync2    <= '0;
      full        <= 1'b0;
      wr_count    <= '0;
      rst_hold    <= 1'b1;
    end else begin
      rd_sync1    <= rd_ptr_gray;
      rd_sync2    <= rd_sync1;
      wr_bin      <= wr_bin_next;
      wr_ptr_gray <= wr_gray_next;
      full        <= full_next;
      wr_count    <= wr_count_next;
      rst_hold    <= 1'b0;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [LSIZE:0] AF_THRESH_W = AF_THRESH[LSIZE:0];

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (wr_count_next >= AF_THRESH_W);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Testbench for fifo_wr_ctrl (SIZE=64, WIDTH=16, AF_THRESH=60).
// The reference model tracks the FIFO as integer write/read counts, with the
// read count delayed by two write-clock edges.

module tb_fifo_wr_ctrl;

  localparam int WIDTH = 16;
  localparam int SIZE  = 64;
  localparam int LSIZE = 6;
  localparam int AF    = 60;
  localparam int PMOD  = 2 * SIZE;

  logic             clk_wr = 1'b0;
  logic             rst_wr;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [LSIZE:0]   rd_ptr_gray;
  logic [LSIZE:0]   wr_ptr_gray;
  logic             mem_wr_en;
  logic [LSIZE-1:0] mem_wr_addr;
  logic [WIDTH-1:0] mem_data;
  logic             full;
  logic [LSIZE:0]   wr_count;
`ifdef FIFO_ALMOST_FULL_EN
  logic             almost_full;
`endif

  always #5 clk_wr = ~clk_wr;

  fifo_wr_ctrl #(
    .WIDTH(WIDTH), .SIZE(SIZE), .LSIZE(LSIZE), .AF_THRESH(AF)
  ) dut (
    .clk_wr      (clk_wr),
    .rst_wr      (rst_wr),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .rd_ptr_gray (rd_ptr_gray),
    .wr_ptr_gray (wr_ptr_gray),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_data    (mem_data),
    .full        (full),
    .wr_count    (wr_count)
`ifdef FIFO_ALMOST_FULL_EN
    ,
    .almost_full (almost_full)
`endif
  );

  int vectors = 0;
  int errors  = 0;

  // reference model state
  int m_wr     = 0;   // write pointer mod 2*SIZE
  int m_wr_tot = 0;   // writes accepted since reset
  int m_s1     = 0;   // read count, one edge old
  int m_s2     = 0;   // read count, two edges old
  int m_occ    = 0;
  bit m_full   = 1'b0;
  bit m_af     = 1'b0;
  bit m_rdy_ok = 1'b0;
  int rd_total = 0;

  typedef struct {
    bit          rst;
    bit          vld;
    bit          incr;
    logic [15:0] data;
    int          rd;
    int          ncyc;
    bit          e_full;
    int          e_count;
    int          e_wrbin;
    bit          e_ready;
  } step_t;

  step_t steps [12];

  function automatic logic [LSIZE:0] gray(input int v);
    logic [LSIZE:0] b;
    b = v[LSIZE:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit vld, input logic [15:0] data, input int rd);
    rst_wr      = rst;
    in_valid    = vld;
    in_data     = data;
    rd_total    = rd;
    rd_ptr_gray = gray(rd % PMOD);
  endtask

  // Check the combinational outputs, advance one edge, update the model, then
  // check the registered outputs on the falling edge.
  task automatic tick();
    bit exp_rdy;
    bit exp_acc;
    #1;
    exp_rdy = !rst_wr && m_rdy_ok && !m_full;
    exp_acc = exp_rdy && in_valid;
    check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    check("mem_wr_en", {31'b0, mem_wr_en}, {31'b0, exp_acc});
    if (exp_acc) begin
      check("mem_wr_addr", {26'b0, mem_wr_addr}, m_wr % SIZE);
      check("mem_data", {16'b0, mem_data}, {16'b0, in_data});
    end
    @(posedge clk_wr);
    if (rst_wr) begin
      m_wr = 0; m_wr_tot = 0; m_s1 = 0; m_s2 = 0; m_occ = 0;
      m_full = 1'b0; m_af = 1'b0; m_rdy_ok = 1'b0;
    end else begin
      if (exp_acc) begin
        m_wr = (m_wr + 1) % PMOD;
        m_wr_tot++;
      end
      m_occ  = (m_wr - m_s2 + PMOD) % PMOD;
      m_full = (m_occ == SIZE);
      m_af   = (m_occ >= AF);
      m_s2   = m_s1;
      m_s1   = rd_total % PMOD;
      m_rdy_ok = 1'b1;
    end
    @(negedge clk_wr);
    check("full", {31'b0, full}, {31'b0, m_full});
    check("wr_count", {25'b0, wr_count}, m_occ);
    check("wr_ptr_gray", {25'b0, wr_ptr_gray}, {25'b0, gray(m_wr)});
`ifdef FIFO_ALMOST_FULL_EN
    check("almost_full", {31'b0, almost_full}, {31'b0, m_af});
`endif
  endtask

  initial begin
    bit full_seen;
    int rate;

    //             rst   vld   incr  data      rd  n   full  cnt wrbin rdy
    steps[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 0,  2,  1'b0, 0,  0,  1'b0};
    steps[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 0,  1,  1'b0, 0,  0,  1'b1};
    steps[2]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 0,  64, 1'b1, 64, 64, 1'b0};
    steps[3]  = '{1'b0, 1'b1, 1'b0, 16'hDEAD, 0,  5,  1'b1, 64, 64, 1'b0};
    steps[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1,  2,  1'b1, 64, 64, 1'b0};
    steps[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1,  1,  1'b0, 63, 64, 1'b1};
    steps[6]  = '{1'b0, 1'b1, 1'b0, 16'h0100, 1,  1,  1'b1, 64, 65, 1'b0};
    steps[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 34, 3,  1'b0, 31, 65, 1'b1};
    steps[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 35, 3,  1'b0, 30, 65, 1'b1};
    steps[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 0,  1,  1'b0, 0,  0,  1'b0};
    steps[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 0,  1,  1'b0, 0,  0,  1'b1};
    steps[11] = '{1'b0, 1'b1, 1'b0, 16'h0AA0, 0,  1,  1'b0, 1,  1,  1'b1};

    drive(1'b1, 1'b0, 16'h0, 0);
    @(negedge clk_wr);

    // table-driven directed sequence
    for (int s = 0; s < 12; s++) begin
      for (int c = 0; c < steps[s].ncyc; c++) begin
        drive(steps[s].rst, steps[s].vld,
              steps[s].incr ? steps[s].data + 16'(c) : steps[s].data, steps[s].rd);
        tick();
      end
      check($sformatf("step%0d_full", s), {31'b0, full}, {31'b0, steps[s].e_full});
      check($sformatf("step%0d_count", s), {25'b0, wr_count}, steps[s].e_count);
      check($sformatf("step%0d_wrptr", s), {25'b0, wr_ptr_gray}, {25'b0, gray(steps[s].e_wrbin)});
      check($sformatf("step%0d_ready", s), {31'b0, in_ready}, {31'b0, steps[s].e_ready});
    end

    // 200-word stream while the read side keeps up: wraps past 127 without full
    drive(1'b1, 1'b0, 16'h0, 0); tick();
    drive(1'b0, 1'b0, 16'h0, 0); tick();
    full_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      drive(1'b0, 1'b1, 16'(i), m_wr_tot);
      tick();
      full_seen |= full;
    end
    check("wrap_no_full", {31'b0, full_seen}, 32'd0);
    check("wrap_wrptr", {25'b0, wr_ptr_gray}, {25'b0, gray(200 % PMOD)});

`ifdef FIFO_ALMOST_FULL_EN
    drive(1'b1, 1'b0, 16'h0, 0); tick();
    drive(1'b0, 1'b0, 16'h0, 0); tick();
    for (int i = 0; i < 60; i++) begin
      drive(1'b0, 1'b1, 16'(i), 0);
      tick();
    end
    check("af_at_60", {31'b0, almost_full}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 16'h0, 1);
      tick();
    end
    check("af_at_59", {31'b0, almost_full}, 32'd0);
    check("af_count_59", {25'b0, wr_count}, 32'd59);
`endif

    // randomized traffic with a varying read rate and occasional reset
    drive(1'b1, 1'b0, 16'h0, 0); tick();
    for (int i = 0; i < 4000; i++) begin
      bit r;
      bit v;
      int rd;
      rate = (i / 500) % 3;
      r  = ($urandom_range(0, 399) == 0);
      v  = ($urandom_range(0, 3) != 0);
      rd = rd_total;
      if (r) begin
        rd = 0;
      end else if (rd < m_wr_tot) begin
        case (rate)
          0:       if ($urandom_range(0, 7) == 0) rd++;
          1:       if ($urandom_range(0, 1) == 0) rd++;
          default: if ($urandom_range(0, 7) != 0) rd++;
        endcase
      end
      drive(r, v, 16'($urandom), rd);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
